shift_right_seq: RTL and testbench
==================================

SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: operand request valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept an operand.
REQ-005 SHALL have port a_in, input, 16 bits: operand to shift.
REQ-006 SHALL have port shft_amt, input, 4 bits: shift distance, 0..15.
REQ-007 SHALL have port arith, input, 1 bit: 1 = arithmetic (sign fill), 0 = logical (zero fill).
REQ-008 SHALL have port out_valid, output, 1 bit: result on o is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-010 SHALL have port o, output, 16 bits: registered result.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 SHALL drive in_ready = 1 only in IDLE, combinationally from state.
REQ-013 SHALL drive out_valid = 1 only in DONE, combinationally from state.
REQ-014 Accept on an edge with in_valid=1 in IDLE: SHALL capture a_in into data register, shft_amt into 4-bit counter, arith into mode flag.
REQ-015 On accept with shft_amt=0: SHALL go IDLE->DONE with data unchanged.
REQ-016 On accept with shft_amt!=0: SHALL go IDLE->SHIFT.
REQ-017 In SHIFT, each edge: SHALL shift data right 1 bit, filling bit 15 with old bit 15 if mode=1, else 0; SHALL decrement counter.
REQ-018 In SHIFT with counter=1 at the edge: SHALL perform the final shift and go to DONE.
REQ-019 Latency: out_valid SHALL rise shft_amt+1 cycles after the accepting edge's cycle, i.e. exactly shft_amt shift edges after accept.
REQ-020 In DONE: o and out_valid SHALL hold stable while out_ready=0.
REQ-021 In DONE with out_ready=1 at an edge: SHALL go to IDLE; in_ready asserts the following cycle.
REQ-022 in_valid, a_in, shft_amt and arith SHALL be ignored outside IDLE.
REQ-023 o SHALL always reflect the data register; it is meaningful only when out_valid=1.
REQ-024 Result SHALL equal a_in >> shft_amt for logical mode and signed a_in >>> shft_amt for arithmetic mode, 16-bit, no overflow flag.

Reset
REQ-025 On an edge with rst_n=0: state SHALL become IDLE, data register 0x0000, counter 0, mode 0.
REQ-026 While in reset state: o=0x0000, out_valid=0, in_ready=1.
REQ-027 Reset in SHIFT or DONE SHALL abort the operation with no result emitted.

Structure
REQ-028 Shared package SHALL hold DATA_W=16, SHAMT_W=4 and the FSM state enum.
REQ-029 The single-bit shift step SHALL be a combinational sub-module shr_step: 16-bit in, mode in, 16-bit out.
REQ-030 Control (FSM, counter) and datapath register SHALL reside in shift_right_seq; no latches; one clock domain.

Verification
REQ-031 a_in=0x8001, shft_amt=4, arith=0 -> o=0x0800, out_valid rises 4 edges after accept.
REQ-032 a_in=0x8001, shft_amt=4, arith=1 -> o=0xF800.
REQ-033 a_in=0x1234, shft_amt=0 -> o=0x1234, out_valid on the cycle after accept.
REQ-034 a_in=0x8000, shft_amt=15: arith=1 -> 0xFFFF; arith=0 -> 0x0001; 15 shift edges each.
REQ-035 out_ready held 0 for 3 cycles in DONE -> o and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-036 rst_n=0 for one edge mid-SHIFT (a_in=0xFFFF, shft_amt=8) -> next cycle IDLE, o=0x0000, out_valid=0, no result emitted.

Source files
------------

// File: rtl/shift_right_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_right_seq_pkg : widths and FSM states for the serial shifter. |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package shift_right_seq_pkg;

    localparam int DATA_W  = 16;
    localparam int SHAMT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : shift_right_seq_pkg
`default_nettype wire

// File: rtl/shift_right_seq_shr_step.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shr_step : one-bit right shift, sign fill when mode=1 else zero.    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module shr_step
    import shift_right_seq_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    input  logic              mode,
    output logic [DATA_W-1:0] q
);

    assign q = {mode & d[DATA_W-1], d[DATA_W-1:1]};

endmodule : shr_step
`default_nettype wire

// File: rtl/shift_right_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_right_seq : 16-bit right shifter, one bit per clock, handshake|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module shift_right_seq
    import shift_right_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  a_in,
    input  logic [SHAMT_W-1:0] shft_amt,
    input  logic               arith,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  o
);

    state_t               state;
    logic [DATA_W-1:0]    data;
    logic [SHAMT_W-1:0]   cnt;
    logic                 mode;
    logic [DATA_W-1:0]    step_q;

    shr_step u_step (
        .d    (data),
        .mode (mode),
        .q    (step_q)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign o         = data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            data  <= '0;
            cnt   <= '0;
            mode  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data  <= a_in;
                        cnt   <= shft_amt;
                        mode  <= arith;
                        state <= (shft_amt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    // The edge that sees cnt==1 performs the last shift.
                    data <= step_q;
                    cnt  <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : shift_right_seq
`default_nettype wire

// File: tb/tb_shift_right_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_shift_right_seq : directed + random checks against a shift model.|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_shift_right_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a_in = 16'h0;
    logic [3:0]  shft_amt = 4'h0;
    logic        arith = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] o;

    int compared   = 0;
    int mismatched = 0;

    shift_right_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .shft_amt  (shft_amt),
        .arith     (arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an operation is idle, waiting out its shift edges, or holding its result.
    logic        m_idle  = 1'b1;
    logic        m_done  = 1'b0;
    int          m_left  = 0;
    logic [15:0] m_res   = 16'h0;
    int          m_edges = 0;

    always @(posedge clk) begin
        m_edges <= m_edges + 1;
        if (!rst_n) begin
            m_idle <= 1'b1;
            m_done <= 1'b0;
            m_res  <= 16'h0;
        end else if (m_idle) begin
            if (in_valid) begin
                if (arith) m_res <= $signed(a_in) >>> shft_amt;
                else       m_res <= a_in >> shft_amt;
                m_left <= int'(shft_amt);
                m_idle <= 1'b0;
                m_done <= (shft_amt == 4'd0);
            end
        end else if (!m_done) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1'b1;
        end else if (out_ready) begin
            m_idle <= 1'b1;
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_edges > 0) begin
            chk("model_in_ready", {31'd0, in_ready}, {31'd0, m_idle});
            chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_done});
            if (m_done) chk("model_o", {16'd0, o}, {16'd0, m_res});
        end
    end

    // Issue one operation, measure shift edges to out_valid, optionally stall in DONE.
    task automatic run_op(input logic [15:0] a, input logic [3:0] n, input logic ar,
                          input logic [15:0] exp, input int hold);
        int edges;
        logic [15:0] held;
        chk("op_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; a_in = a; shft_amt = n; arith = ar; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("op_latency", edges, {28'd0, n});
        chk("op_result", {16'd0, o}, {16'd0, exp});
        held = o;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a_in = 16'h5A5A; shft_amt = 4'd3; arith = 1'b1;
            @(posedge clk); #1;
            chk("hold_o", {16'd0, o}, {16'd0, held});
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o", {16'd0, o}, 32'h0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;

        run_op(16'h8001, 4'd4,  1'b0, 16'h0800, 0);
        run_op(16'h8001, 4'd4,  1'b1, 16'hF800, 0);
        run_op(16'h1234, 4'd0,  1'b0, 16'h1234, 0);
        run_op(16'h8000, 4'd15, 1'b1, 16'hFFFF, 0);
        run_op(16'h8000, 4'd15, 1'b0, 16'h0001, 0);
        run_op(16'hC3A5, 4'd2,  1'b1, 16'hF0E9, 3);

        // Abort mid-shift with a one-edge reset.
        in_valid = 1'b1; a_in = 16'hFFFF; shft_amt = 4'd8; arith = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_o", {16'd0, o}, 32'h0);
        repeat (10) begin
            @(posedge clk); #1;
            chk("abort_no_result", {31'd0, out_valid}, 32'd0);
        end

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(1, 0) == 1);
            a_in      = 16'($urandom);
            shft_amt  = 4'($urandom);
            arith     = ($urandom_range(1, 0) == 1);
            out_ready = ($urandom_range(9, 0) < 6);
            rst_n     = ($urandom_range(99, 0) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_shift_right_seq
`default_nettype wire
